toeplitz_outbuf: RTL and testbench

//  Downstream stage of the Toeplitz extractor. Captures each L-bit extracted block
//  (q, qstrobe) into a DEPTH-entry block FIFO. Serializes the FIFO into W-bit words
//  on a valid/ready stream toward the host interface, so consumer stalls do not lose

---
 rtl/toeplitz_outbuf.sv | 110 +++++++++++
 tb/tb_toeplitz_outbuf.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/toeplitz_outbuf.sv
// toeplitz_outbuf
//   Output stage of the Toeplitz extractor. Each L-bit block presented with a
//   qstrobe pulse is captured into a DEPTH-entry block FIFO, then streamed out as
//   L/W words of W bits, least-significant word first, on a valid/ready handshake.
//   A block arriving while the FIFO is full is dropped, unless the head block's
//   final word leaves in that same cycle.
//
// Ports
//   clk       in   clock, everything on posedge
//   reset     in   synchronous active-low reset; flushes FIFO and partial head block
//   q         in   L-bit extracted block, sampled when qstrobe=1
//   qstrobe   in   one-cycle pulse marking a new block on q
//   dout      out  current W-bit output word (registered state only)
//   dvalid    out  dout valid (FIFO not empty)
//   dready    in   consumer accepts dout this cycle
//   overflow  out  one-cycle pulse the cycle after a block was dropped
//   level     out  blocks held, including a partially sent head block
//   drop_cnt  out  saturating 16-bit dropped-block counter
//                  (only when TOEPLITZ_OUTBUF_DROPCNT_EN is defined)
//
// Build option
//   TOEPLITZ_OUTBUF_DROPCNT_EN : adds the drop_cnt port and register.

module toeplitz_outbuf #(
  parameter int L     = 128,
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [L-1:0]             q,
  input  logic                     qstrobe,
  output logic [W-1:0]             dout,
  output logic                     dvalid,
  input  logic                     dready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
`ifdef TOEPLITZ_OUTBUF_DROPCNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int NW = L / W;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  logic [L-1:0]          mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [IW-1:0]         widx_q;
  logic [AW:0]           level_q, level_d;
  logic                  ovf_q;
  logic [NW-1:0][W-1:0]  head;

  logic xfer, last, full, wr_en, drop;

  // Head block viewed as a word array; word select is driven only by registers.
  assign head   = mem_q[rd_ptr_q];
  assign dout   = head[widx_q];
  assign dvalid = (level_q != '0);

  assign xfer  = dvalid & dready;
  assign last  = xfer & (widx_q == IW'(NW - 1));
  assign full  = (level_q == (AW+1)'(DEPTH));
  // A full FIFO still takes the block if the head frees its slot this cycle.
  assign wr_en = qstrobe & (~full | last);
  assign drop  = qstrobe & full & ~last;

  assign level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(last);

  assign level    = level_q;
  assign overflow = ovf_q;

  // Block storage is not reset; contents are only visible through dvalid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      widx_q   <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (last) begin
        widx_q   <= '0;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end else if (xfer) begin
        widx_q   <= widx_q + 1'b1;
      end
      level_q <= level_d;
      ovf_q   <= drop;
    end
  end

`ifdef TOEPLITZ_OUTBUF_DROPCNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)                             drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_toeplitz_outbuf.sv
module tb_toeplitz_outbuf;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] q;
  logic         qstrobe;
  logic [31:0]  dout;
  logic         dvalid;
  logic         dready;
  logic         overflow;
  logic [2:0]   level;
`ifdef TOEPLITZ_OUTBUF_DROPCNT_EN
  logic [15:0]  drop_cnt;
`endif

  always #5 clk = ~clk;

  toeplitz_outbuf #(.L(128), .W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .q(q), .qstrobe(qstrobe),
    .dout(dout), .dvalid(dvalid), .dready(dready),
    .overflow(overflow), .level(level)
`ifdef TOEPLITZ_OUTBUF_DROPCNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [127:0] m_q[$];
  int           m_w   = 0;
  logic         m_ovf = 1'b0;
  logic [15:0]  m_dc  = '0;
  logic         hold_v = 1'b0;
  logic [31:0]  hold_d;

  // values observed in the last step (state before that step's clock edge)
  logic [31:0]  o_dout;
  logic         o_dv, o_ovf;
  logic [2:0]   o_lvl;

  function automatic logic [127:0] mkblk(input int n);
    logic [127:0] b;
    for (int j = 0; j < 4; j++) b[j*32 +: 32] = 32'hA000_0000 | (n << 8) | j;
    return b;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic rs, input logic stb, input logic [127:0] qv, input logic rdy);
    logic [127:0] hb;
    logic xf, lst, fl;
    @(negedge clk);
    reset = rs; qstrobe = stb; q = qv; dready = rdy;
    #1;
    o_dout = dout; o_dv = dvalid; o_lvl = level; o_ovf = overflow;
    chk("dvalid", {63'd0, dvalid}, {63'd0, m_q.size() != 0});
    chk("level", {61'd0, level}, 64'(m_q.size()));
    chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
`ifdef TOEPLITZ_OUTBUF_DROPCNT_EN
    chk("drop_cnt", {48'd0, drop_cnt}, {48'd0, m_dc});
`endif
    if (m_q.size() != 0) begin
      hb = m_q[0];
      chk("dout", {32'd0, dout}, {32'd0, hb[m_w*32 +: 32]});
    end
    if (hold_v) chk("stall_hold", {32'd0, dout}, {32'd0, hold_d});
    hold_v = rs && (m_q.size() != 0) && !rdy;
    hold_d = dout;
    if (!rs) begin
      m_q.delete(); m_w = 0; m_ovf = 1'b0; m_dc = '0;
    end else begin
      xf    = (m_q.size() != 0) && rdy;
      lst   = xf && (m_w == 3);
      fl    = (m_q.size() == 4);
      m_ovf = stb && fl && !lst;
      if (m_ovf && m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
      if (lst) begin
        m_w = 0;
        void'(m_q.pop_front());
      end else if (xf) m_w++;
      if (stb && !m_ovf) m_q.push_back(qv);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [127:0] b1, bn;
    reset = 1'b0; qstrobe = 1'b0; q = '0; dready = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    step(1'b1, 1'b0, '0, 1'b0);
    chk("rst_dvalid", {63'd0, o_dv}, 64'd0);
    chk("rst_level", {61'd0, o_lvl}, 64'd0);
    chk("rst_ovf", {63'd0, o_ovf}, 64'd0);

    // 1. single block, LSW first, one-cycle latency
    b1 = 128'h01234567_89ABCDEF_8899AABB_CCDDEEFF;
    step(1'b1, 1'b1, b1, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("t1_dv_rise", {63'd0, o_dv}, 64'd1);
    chk("t1_w0", {32'd0, o_dout}, 64'hCCDDEEFF);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("t1_w1", {32'd0, o_dout}, 64'h8899AABB);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("t1_w2", {32'd0, o_dout}, 64'h89ABCDEF);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("t1_w3", {32'd0, o_dout}, 64'h01234567);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("t1_dv_fall", {63'd0, o_dv}, 64'd0);
    chk("t1_lvl", {61'd0, o_lvl}, 64'd0);

    // 2. stalled consumer, 5 strobes, 5th dropped
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, mkblk(i), 1'b0);
    chk("t2_lvl4", {61'd0, o_lvl}, 64'd4);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("t2_ovf", {63'd0, o_ovf}, 64'd1);
    chk("t2_lvl", {61'd0, o_lvl}, 64'd4);
`ifdef TOEPLITZ_OUTBUF_DROPCNT_EN
    chk("t2_dc", {48'd0, drop_cnt}, 64'd1);
`endif
    step(1'b1, 1'b0, '0, 1'b1);
    chk("t2_ovf_pulse", {63'd0, o_ovf}, 64'd0);
    chk("t2_first", {32'd0, o_dout}, 64'hA000_0000);
    drain(15);
    chk("t2_last", {32'd0, o_dout}, 64'hA000_0303);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("t2_empty", {63'd0, o_dv}, 64'd0);

    // 3. full FIFO, strobe coincident with last word of head
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, mkblk(16 + i), 1'b0);
    drain(3);
    bn = mkblk(32);
    step(1'b1, 1'b1, bn, 1'b1);
    chk("t3_w3", {32'd0, o_dout}, 64'hA000_1003);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("t3_no_ovf", {63'd0, o_ovf}, 64'd0);
    chk("t3_lvl", {61'd0, o_lvl}, 64'd4);
    drain(16);
    chk("t3_new_last", {32'd0, o_dout}, 64'hA000_2003);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("t3_empty", {63'd0, o_dv}, 64'd0);

    // 4. random backpressure, strobe every 8 cycles, 1000 blocks
    for (int c = 0; c < 8000; c++)
      step(1'b1, (c % 8) == 0, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    drain(24);

    // 5. reset mid-block with 3 blocks queued
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, mkblk(40 + i), 1'b0);
    drain(2);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("t5_pre_w2", {32'd0, o_dout}, 64'hA000_2802);
    step(1'b1, 1'b1, mkblk(50), 1'b0);
    chk("t5_dv", {63'd0, o_dv}, 64'd0);
    chk("t5_lvl", {61'd0, o_lvl}, 64'd0);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("t5_dv_new", {63'd0, o_dv}, 64'd1);
    chk("t5_w0", {32'd0, o_dout}, 64'hA000_3200);
    drain(4);

`ifdef TOEPLITZ_OUTBUF_DROPCNT_EN
    // 6. drop counter saturation
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, mkblk(60 + i), 1'b0);
    for (int i = 0; i < 70000; i++) step(1'b1, 1'b1, mkblk(99), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("t6_sat", {48'd0, drop_cnt}, 64'hFFFF);
    step(1'b1, 1'b1, mkblk(99), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("t6_sat_hold", {48'd0, drop_cnt}, 64'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
